// File: rtl/fpa_pkg.sv
// Shared types and constants for the fpa byte-stream front end.
package fpa_pkg;

  typedef enum logic [2:0] {
    CMD,
    LOAD_A,
    LOAD_B,
    SETTLE,
    SEND
  } state_e;

  localparam logic              OP_ADD        = 1'b0;
  localparam logic              OP_MUL        = 1'b1;
  localparam int unsigned       FRAME_BYTES   = 9;
  localparam logic [7:0]        CMD_RSVD_MASK = 8'hFE;

  // Byte of a 32-bit word in MSB-first order: idx 0 is [31:24].
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fpa_byte_serializer.sv
// Holds a 32-bit word and emits it MSB-first as four bytes on a valid/ready stream.
module fpa_byte_serializer
  import fpa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        last_xfer
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        xfer;

  assign xfer      = valid_q & out_ready;
  assign last_xfer = xfer & (idx_q == 2'd3);
  assign out_valid = valid_q;
  assign out_data  = byte_sel(word_q, idx_q);

  // Next-state: load a fresh word, or step to the next byte on each transfer.
  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      word_d  = load_data;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (idx_q == 2'd3) begin
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // Word, byte index and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fpa_stream_port.sv
// Byte-serial front end for the combinational fpa adder/multiplier:
// collects cmd + A + B from the input stream, lets fpa settle, returns the result.
module fpa_stream_port
  import fpa_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] number_A,
  output logic [31:0] number_B,
  output logic        operator,
  input  logic [31:0] number_out,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] IdleLast   = 16'(TIMEOUT - 1);
  localparam bit          TimeoutEn  = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [31:0] num_a_q, num_a_d;
  logic [31:0] num_b_q, num_b_d;
  logic        op_q, op_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] idle_q, idle_d;
  logic        frame_err_q, frame_err_d;
  logic        in_xfer;
  logic        ser_load;
  logic        ser_last;

  assign in_ready  = (state_q == CMD) || (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_xfer   = in_valid & in_ready;
  assign busy      = (state_q != CMD);
  assign number_A  = num_a_q;
  assign number_B  = num_b_q;
  assign operator  = op_q;
  assign frame_err = frame_err_q;

  // Frame parser, settle timer and idle watchdog.
  always_comb begin
    state_d     = state_q;
    num_a_d     = num_a_q;
    num_b_d     = num_b_q;
    op_d        = op_q;
    byte_idx_d  = byte_idx_q;
    settle_d    = settle_q;
    idle_d      = '0;
    frame_err_d = 1'b0;
    ser_load    = 1'b0;
    case (state_q)
      CMD: begin
        if (in_xfer) begin
          if ((in_data & CMD_RSVD_MASK) == 8'h00) begin
            op_d       = in_data[0] ? OP_MUL : OP_ADD;
            byte_idx_d = '0;
            state_d    = LOAD_A;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (in_xfer) begin
          if (state_q == LOAD_A) num_a_d = {num_a_q[23:0], in_data};
          else                   num_b_d = {num_b_q[23:0], in_data};
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = '0;
            settle_d   = '0;
            state_d    = (state_q == LOAD_A) ? LOAD_B : SETTLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (TimeoutEn && (idle_q == IdleLast)) begin
          state_d     = CMD;
          frame_err_d = 1'b1;
          num_a_d     = '0;
          num_b_d     = '0;
          byte_idx_d  = '0;
        end else begin
          idle_d = (idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1;
        end
      end
      SETTLE: begin
        if (settle_q == SettleLast) begin
          ser_load   = 1'b1;
          settle_d   = '0;
          byte_idx_d = '0;
          state_d    = SEND;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      SEND: begin
        if (ser_last) state_d = CMD;
      end
      default: state_d = CMD;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CMD;
      num_a_q     <= '0;
      num_b_q     <= '0;
      op_q        <= OP_ADD;
      byte_idx_q  <= '0;
      settle_q    <= '0;
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_a_q     <= num_a_d;
      num_b_q     <= num_b_d;
      op_q        <= op_d;
      byte_idx_q  <= byte_idx_d;
      settle_q    <= settle_d;
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
    end
  end

  fpa_byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (number_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last_xfer (ser_last)
  );

endmodule

// File: tb/tb_fpa_stream_port.sv
// Randomized self-checking bench for fpa_stream_port with a behavioural fpa model.
module tb_fpa_stream_port;
  import fpa_pkg::*;

  localparam int unsigned S  = 3;
  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] number_A;
  logic [31:0] number_B;
  logic        operator;
  logic [31:0] number_out;
  logic        busy;
  logic        frame_err;

  logic [7:0]  exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned err_seen = 0;
  int unsigned err_exp = 0;
  int unsigned rdy_mode = 0;
  logic [31:0] last_word = '0;
  logic        last_op = 1'b0;

  fpa_stream_port #(.SETTLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .number_A   (number_A),
    .number_B   (number_B),
    .operator   (operator),
    .number_out (number_out),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single precision <-> real for normal values and zero.
  function automatic real sp2real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpa_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    real ra, rb;
    ra = sp2real(a);
    rb = sp2real(b);
    return op ? real2sp(ra * rb) : real2sp(ra + rb);
  endfunction

  function automatic logic [31:0] rand_sp();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    e = 8'($urandom_range(110, 144));
    return {r[31], e, r[22:0]};
  endfunction

  assign number_out = fpa_model(number_A, number_B, operator);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sink ready pattern, changed just after each rising edge.
  initial begin
    int unsigned stall_ctr = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          stall_ctr = (stall_ctr == 5) ? 0 : stall_ctr + 1;
          out_ready = (stall_ctr == 5);
        end
      endcase
    end
  end

  // Output monitor: scoreboard, stall stability, in_ready during SEND, frame_err pulses.
  initial begin
    logic [7:0] held;
    logic       hold_v;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (frame_err) err_seen++;
        if (out_valid) begin
          check_eq("in_ready_send", 32'(in_ready), 32'd0);
          if (hold_v) check_eq("stall_stable", 32'(out_data), 32'(held));
          if (out_ready) begin
            check_eq("out_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
            last_word = {last_word[23:0], out_data};
            hold_v = 1'b0;
          end else begin
            held   = out_data;
            hold_v = 1'b1;
          end
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  // Call at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned gap_max);
    logic [63:0] ops;
    logic [31:0] r;
    int unsigned lat;
    ops = {a, b};
    send_byte(cmd);
    if ((cmd & CMD_RSVD_MASK) != 8'h00) begin
      err_exp++;
      return;
    end
    last_op = cmd[0];
    for (int unsigned i = 1; i < FRAME_BYTES; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(ops[8*(FRAME_BYTES-1-i) +: 8]);
    end
    r = fpa_model(a, b, cmd[0]);
    for (int unsigned j = 0; j < 4; j++) exp_q.push_back(r[8*(3-j) +: 8]);
    lat = 0;
    while (!out_valid && lat < 100) begin
      check_eq("op_settle", 32'(operator), 32'(cmd[0]));
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, S);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check_eq("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned k;
    logic [7:0]  cmd;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_num_a", number_A, 32'd0);
    check_eq("rst_num_b", number_B, 32'd0);
    check_eq("rst_op", 32'(operator), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Add and multiply
    send_frame(8'h00, 32'h3F800000, 32'h40000000, 0);
    wait_drain();
    check_eq("add_word", last_word, 32'h40400000);
    check_eq("hold_a", number_A, 32'h3F800000);
    check_eq("hold_b", number_B, 32'h40000000);
    send_frame(8'h01, 32'h40000000, 32'h40400000, 0);
    wait_drain();
    check_eq("mul_word", last_word, 32'h40C00000);
    check_eq("hold_op", 32'(operator), 32'd1);

    // Backpressure; the second cmd byte is offered while the first result is stalled
    rdy_mode = 2;
    send_frame(8'h00, 32'h3F800000, 32'h40400000, 0);
    send_frame(8'h01, 32'h40400000, 32'h40400000, 0);
    wait_drain();
    check_eq("bp_word", last_word, 32'h41100000);
    rdy_mode = 0;

    // Reserved command bits set
    send_byte(8'h82);
    err_exp++;
    check_eq("bad_cmd_err", 32'(frame_err), 32'd1);
    check_eq("bad_cmd_busy", 32'(busy), 32'd0);
    check_eq("bad_cmd_op", 32'(operator), 32'(last_op));
    @(negedge clk);
    check_eq("bad_cmd_err_1cyc", 32'(frame_err), 32'd0);
    send_frame(8'h00, 32'h3F800000, 32'h3F800000, 0);
    wait_drain();
    check_eq("after_bad_word", last_word, 32'h40000000);

    // Stall mid-A until the watchdog aborts the frame
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    k = 0;
    while (!frame_err && k < 60) begin
      @(negedge clk);
      k++;
    end
    err_exp++;
    check_eq("timeout_cycle", k, TO);
    check_eq("timeout_busy", 32'(busy), 32'd0);
    check_eq("timeout_num_a", number_A, 32'd0);
    check_eq("timeout_num_b", number_B, 32'd0);
    check_eq("timeout_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Reset after 5 bytes of a frame
    send_byte(8'h01);
    send_byte(8'hC1);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("pre_rst_num_a", number_A, 32'hC1200000);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_num_a", number_A, 32'd0);
    check_eq("arst_op", 32'(operator), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    send_frame(8'h01, 32'hC1200000, 32'h3F000000, 1);
    wait_drain();
    check_eq("post_rst_word", last_word, 32'hC0A00000);

    // Reset while a result is being stalled on the output
    rdy_mode = 2;
    send_frame(8'h00, 32'h40000000, 32'h40000000, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_out_data", 32'(out_data), 32'd0);
    check_eq("arst_num_b", number_B, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    send_frame(8'h00, 32'h40000000, 32'h40000000, 0);
    wait_drain();
    check_eq("post_send_rst_word", last_word, 32'h40800000);

    // Randomized frames with gaps, random sink readiness and occasional bad commands
    rdy_mode = 1;
    for (int unsigned f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) cmd = 8'($urandom_range(2, 255));
      else cmd = 8'($urandom_range(0, 1));
      send_frame(cmd, rand_sp(), rand_sp(), 4);
      if ((cmd & CMD_RSVD_MASK) == 8'h00) wait_drain();
    end
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check_eq("frame_err_count", err_seen, err_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
